// File: rtl/pc_stack_sequencer_if.sv
// Bus between the core, the PC sequencer and the return-address LIFO.
// step is a single-cycle accept strobe: an instruction is taken on any rising edge with step=1 and busy=0.
interface pc_stack_sequencer_if #(
  parameter int PC_W = 11
);
  logic            step;
  logic [2:0]      op;
  logic            cond;
  logic [PC_W-1:0] target;
  logic            irq;
  logic            irq_en;
  logic [PC_W-1:0] stk_dout;
  logic [PC_W-1:0] pc;
  logic            stk_wr_en;
  logic            stk_rd_en;
  logic [PC_W-1:0] stk_din;
  logic [3:0]      depth;
  logic            in_isr;
  logic            busy;
  logic            overflow;
  logic            underflow;
  logic            state_dbg;

  modport master (
    output step, op, cond, target, irq, irq_en, stk_dout,
    input  pc, stk_wr_en, stk_rd_en, stk_din, depth, in_isr, busy,
           overflow, underflow, state_dbg
  );

  modport slave (
    input  step, op, cond, target, irq, irq_en, stk_dout,
    output pc, stk_wr_en, stk_rd_en, stk_din, depth, in_isr, busy,
           overflow, underflow, state_dbg
  );
endinterface

// File: rtl/pc_stack_sequencer.sv
// Next-PC sequencer for the 8-bit RISC core: drives the return-address LIFO,
// tracks its depth and handles call/return and non-nesting interrupt entry.
module pc_stack_sequencer #(
  parameter int              PC_W         = 11,
  parameter int              STACK_DEPTH  = 15,
  parameter logic [PC_W-1:0] RESET_VECTOR = '0,
  parameter logic [PC_W-1:0] IRQ_VECTOR   = PC_W'(8)
) (
  input logic                 clk,
  input logic                 rst,
  pc_stack_sequencer_if.slave s
);

  typedef enum logic {
    ST_RUN      = 1'b0,
    ST_RET_LOAD = 1'b1
  } state_e;

  localparam logic [2:0] OP_JUMP   = 3'd1;
  localparam logic [2:0] OP_CALL   = 3'd2;
  localparam logic [2:0] OP_RET    = 3'd3;
  localparam logic [2:0] OP_BRANCH = 3'd4;
  localparam logic [2:0] OP_RETI   = 3'd5;

  localparam logic [3:0] DEPTH_MAX = 4'(STACK_DEPTH);

  state_e          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [3:0]      depth_q, depth_d;
  logic            in_isr_q, in_isr_d;
  logic            overflow_q, overflow_d;
  logic            underflow_q, underflow_d;

  logic            accept;
  logic            irq_take;
  logic            is_ret;
  logic            do_push;
  logic            do_pop;
  logic [PC_W-1:0] pc_inc;

  assign pc_inc   = pc_q + PC_W'(1);
  assign accept   = (state_q == ST_RUN) && s.step;
  assign irq_take = accept && s.irq && s.irq_en && !in_isr_q;
  assign is_ret   = (s.op == OP_RET) || (s.op == OP_RETI);
  // An interrupt entry swallows whatever op arrived with it.
  assign do_push  = irq_take || (accept && (s.op == OP_CALL));
  assign do_pop   = accept && !irq_take && is_ret && (depth_q != 4'd0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_RUN;
      pc_q        <= RESET_VECTOR;
      depth_q     <= 4'd0;
      in_isr_q    <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      depth_q     <= depth_d;
      in_isr_q    <= in_isr_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    depth_d     = depth_q;
    in_isr_d    = in_isr_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    if (state_q == ST_RET_LOAD) begin
      // The LIFO presents the entry just popped during this cycle.
      pc_d    = s.stk_dout;
      state_d = ST_RUN;
    end else if (accept) begin
      if (irq_take) begin
        pc_d     = IRQ_VECTOR;
        in_isr_d = 1'b1;
      end else begin
        case (s.op)
          OP_JUMP:   pc_d = s.target;
          OP_CALL:   pc_d = s.target;
          OP_BRANCH: pc_d = s.cond ? s.target : pc_inc;
          OP_RET, OP_RETI: begin
            if (s.op == OP_RETI) in_isr_d = 1'b0;
            if (do_pop) begin
              depth_d = depth_q - 4'd1;
              state_d = ST_RET_LOAD;
            end else begin
              underflow_d = 1'b1;
              pc_d        = pc_inc;
            end
          end
          default:   pc_d = pc_inc;
        endcase
      end
      if (do_push) begin
        if (depth_q == DEPTH_MAX) overflow_d = 1'b1;
        else                      depth_d    = depth_q + 4'd1;
      end
    end
  end

  always_comb begin
    s.stk_wr_en = 1'b0;
    s.stk_rd_en = 1'b0;
    s.stk_din   = '0;
    s.busy      = (state_q == ST_RET_LOAD);
    if (do_push) begin
      s.stk_wr_en = 1'b1;
      s.stk_din   = irq_take ? pc_q : pc_inc;
    end
    if (do_pop) s.stk_rd_en = 1'b1;
  end

  assign s.pc        = pc_q;
  assign s.depth     = depth_q;
  assign s.in_isr    = in_isr_q;
  assign s.overflow  = overflow_q;
  assign s.underflow = underflow_q;
  assign s.state_dbg = state_q;

  // Push and pop never coincide, and a return-load cycle leaves the LIFO alone.
  a_no_push_pop: assert property (@(posedge clk) disable iff (rst)
    !(s.stk_wr_en && s.stk_rd_en));
  a_busy_quiet: assert property (@(posedge clk) disable iff (rst)
    s.busy |-> !(s.stk_wr_en || s.stk_rd_en));

endmodule

// File: tb/tb_pc_stack_sequencer.sv
// Randomised and directed bench for pc_stack_sequencer with a queue-based
// reference model and a behavioural return-address LIFO.
module tb_pc_stack_sequencer;
  localparam int PC_W = 11;
  localparam logic [PC_W-1:0] IRQ_VEC = 11'h008;
  localparam logic [2:0] NEXT = 3'd0, JUMP = 3'd1, CALL = 3'd2, RET = 3'd3,
                         BRANCH = 3'd4, RETI = 3'd5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pc_stack_sequencer_if #(.PC_W(PC_W)) bus();

  pc_stack_sequencer #(
    .PC_W(PC_W), .STACK_DEPTH(15), .RESET_VECTOR(11'h000), .IRQ_VECTOR(11'h008)
  ) dut (
    .clk(clk),
    .rst(rst),
    .s(bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Environment LIFO: sp is the next free slot, dout shows mem[sp].
  logic [PC_W-1:0] lifo_mem[16];
  int              lifo_sp;

  // Reference model: the expected return-address stack plus architectural flags.
  logic [PC_W-1:0] exp_q[$];
  logic [PC_W-1:0] m_pc, m_ret_pc, n_pc, n_ret_pc;
  bit              m_isr, m_ovf, m_unf, m_ret;
  bit              n_isr, n_ovf, n_unf, n_ret;
  bit              exp_wr, exp_rd, exp_busy;
  logic [PC_W-1:0] exp_din;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, want, $time);
    end
  endtask

  task automatic model_reset();
    m_pc = '0; m_isr = 0; m_ovf = 0; m_unf = 0; m_ret = 0; m_ret_pc = '0;
    exp_q.delete();
    lifo_sp = 0;
  endtask

  task automatic model_push(input logic [PC_W-1:0] v);
    exp_wr = 1; exp_din = v;
    if (exp_q.size() < 15) exp_q.push_back(v);
    else begin
      exp_q[14] = v;
      n_ovf = 1;
    end
  endtask

  task automatic model_eval(input bit st, input logic [2:0] o, input bit c,
                            input logic [PC_W-1:0] t, input bit iq, input bit ie);
    logic [PC_W-1:0] inc;
    inc = m_pc + 11'd1;
    exp_wr = 0; exp_rd = 0; exp_din = '0; exp_busy = 0;
    n_pc = m_pc; n_isr = m_isr; n_ovf = m_ovf; n_unf = m_unf; n_ret = 0; n_ret_pc = m_ret_pc;
    if (m_ret) begin
      exp_busy = 1;
      n_pc = m_ret_pc;
    end else if (st) begin
      if (iq && ie && !m_isr) begin
        model_push(m_pc);
        n_pc = IRQ_VEC;
        n_isr = 1;
      end else if (o == JUMP) n_pc = t;
      else if (o == CALL) begin
        model_push(inc);
        n_pc = t;
      end else if (o == BRANCH) n_pc = c ? t : inc;
      else if (o == RET || o == RETI) begin
        if (o == RETI) n_isr = 0;
        if (exp_q.size() > 0) begin
          exp_rd = 1;
          n_ret_pc = exp_q.pop_back();
          n_ret = 1;
        end else begin
          n_unf = 1;
          n_pc = inc;
        end
      end else n_pc = inc;
    end
  endtask

  // Entered and left at 1 time unit after a rising edge.
  task automatic cycle(input bit st, input logic [2:0] o, input bit c,
                       input logic [PC_W-1:0] t, input bit iq, input bit ie);
    bit s_wr, s_rd;
    logic [PC_W-1:0] s_din;
    bus.step = st; bus.op = o; bus.cond = c; bus.target = t; bus.irq = iq; bus.irq_en = ie;
    #3;
    check("pc", bus.pc, m_pc);
    check("depth", bus.depth, 32'(exp_q.size()));
    check("in_isr", bus.in_isr, m_isr);
    check("overflow", bus.overflow, m_ovf);
    check("underflow", bus.underflow, m_unf);
    model_eval(st, o, c, t, iq, ie);
    check("stk_wr_en", bus.stk_wr_en, exp_wr);
    check("stk_rd_en", bus.stk_rd_en, exp_rd);
    check("stk_din", bus.stk_din, exp_din);
    check("busy", bus.busy, exp_busy);
    s_wr = bus.stk_wr_en; s_rd = bus.stk_rd_en; s_din = bus.stk_din;
    @(posedge clk);
    if (s_wr) begin
      if (lifo_sp < 15) begin
        lifo_mem[lifo_sp] = s_din;
        lifo_sp++;
      end else lifo_mem[14] = s_din;
    end else if (s_rd && lifo_sp > 0) lifo_sp--;
    m_pc = n_pc; m_isr = n_isr; m_ovf = n_ovf; m_unf = n_unf; m_ret = n_ret; m_ret_pc = n_ret_pc;
    #1;
    bus.stk_dout = lifo_mem[lifo_sp];
  endtask

  task automatic op_cycle(input logic [2:0] o, input logic [PC_W-1:0] t);
    cycle(1'b1, o, 1'b0, t, 1'b0, 1'b0);
  endtask

  task automatic idle();
    cycle(1'b0, NEXT, 1'b0, '0, 1'b0, 1'b0);
  endtask

  initial begin
    bus.step = 0; bus.op = '0; bus.cond = 0; bus.target = '0;
    bus.irq = 0; bus.irq_en = 0; bus.stk_dout = '0;
    for (int i = 0; i < 16; i++) lifo_mem[i] = '0;
    model_reset();

    repeat (2) @(posedge clk);
    #1;
    check("rst_pc", bus.pc, 11'h000);
    check("rst_depth", bus.depth, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_strobes", {bus.stk_wr_en, bus.stk_rd_en}, 0);
    check("rst_din", bus.stk_din, 0);
    check("rst_flags", {bus.in_isr, bus.overflow, bus.underflow}, 0);
    rst = 0;

    repeat (3) op_cycle(NEXT, '0);
    check("seq_pc", bus.pc, 11'h003);

    op_cycle(JUMP, 11'h010);
    op_cycle(CALL, 11'h100);
    check("call_pc", bus.pc, 11'h100);
    check("call_depth", bus.depth, 1);
    op_cycle(RET, '0);
    idle();
    check("ret_pc", bus.pc, 11'h011);

    op_cycle(JUMP, 11'h020);
    op_cycle(CALL, 11'h200);
    op_cycle(CALL, 11'h300);
    op_cycle(RET, '0);
    idle();
    check("nest_ret1", bus.pc, 11'h201);
    op_cycle(RET, '0);
    idle();
    check("nest_ret2", bus.pc, 11'h021);

    for (int i = 0; i < 16; i++) op_cycle(CALL, 11'h400 + 11'(i));
    check("ovf_depth", bus.depth, 15);
    check("ovf_flag", bus.overflow, 1);
    for (int i = 0; i < 15; i++) begin
      op_cycle(RET, '0);
      idle();
    end
    check("drain_depth", bus.depth, 0);
    op_cycle(JUMP, 11'h030);
    op_cycle(RET, '0);
    check("unf_flag", bus.underflow, 1);
    check("unf_pc", bus.pc, 11'h031);

    op_cycle(JUMP, 11'h040);
    cycle(1'b1, CALL, 1'b0, 11'h555, 1'b1, 1'b1);
    check("irq_pc", bus.pc, 11'h008);
    check("irq_isr", bus.in_isr, 1);
    repeat (3) cycle(1'b1, NEXT, 1'b0, '0, 1'b1, 1'b1);
    check("isr_masked_pc", bus.pc, 11'h00b);
    cycle(1'b1, RETI, 1'b0, '0, 1'b1, 1'b1);
    cycle(1'b1, NEXT, 1'b0, '0, 1'b0, 1'b1);
    check("reti_pc", bus.pc, 11'h040);
    check("reti_isr", bus.in_isr, 0);

    op_cycle(JUMP, 11'h7ff);
    op_cycle(NEXT, '0);
    check("wrap_pc", bus.pc, 11'h000);
    op_cycle(JUMP, 11'h050);
    cycle(1'b1, BRANCH, 1'b0, 11'h123, 1'b0, 1'b0);
    check("br_nt_pc", bus.pc, 11'h051);
    cycle(1'b1, BRANCH, 1'b1, 11'h123, 1'b0, 1'b0);
    check("br_t_pc", bus.pc, 11'h123);

    op_cycle(CALL, 11'h222);
    op_cycle(RET, '0);
    bus.step = 0;
    #1 rst = 1;
    #1;
    check("arst_pc", bus.pc, 11'h000);
    check("arst_busy", bus.busy, 0);
    check("arst_depth", bus.depth, 0);
    check("arst_flags", {bus.in_isr, bus.overflow, bus.underflow}, 0);
    model_reset();
    @(posedge clk);
    #1;
    rst = 0;
    bus.stk_dout = lifo_mem[0];

    for (int i = 0; i < 800; i++) begin
      cycle(bit'($urandom_range(0, 9) < 8), 3'($urandom_range(0, 7)),
            bit'($urandom_range(0, 1)), 11'($urandom_range(0, 2047)),
            bit'($urandom_range(0, 9) == 0), bit'($urandom_range(0, 9) < 7));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
